// File: rtl/router_fsm.sv
// ---------------------------------------------------------------------------
// router_fsm
// Packet-sequencing controller for the 1x3 router. It decodes the 2-bit
// destination address from the header byte. It then steps the register and
// synchronizer datapath through header, payload and parity loading. It also
// back-pressures the source with busy while the target FIFO is full or has
// not yet drained.
//
// Ports
//   clock                      rising-edge clock
//   resetn                     asynchronous active-low reset
//   pkt_valid                  source packet framing (low on the parity byte)
//   data_in[1:0]               address field of the header byte
//   fifo_full                  full flag of the currently addressed FIFO
//   fifo_empty_0/1/2           empty flags of the three output FIFOs
//   soft_reset_0/1/2           timeout soft resets of the three output FIFOs
//   parity_done                register block captured the parity byte
//   low_packet_valid           pkt_valid fell while the FSM was stalled
//   detect_add                 state is DECODE_ADDRESS
//   lfd_state                  state is LOAD_FIRST_DATA
//   ld_state                   state is LOAD_DATA
//   laf_state                  state is LOAD_AFTER_FULL
//   full_state                 state is FIFO_FULL_STATE
//   rst_int_reg                state is CHECK_PARITY_ERROR
//   write_enb_reg              write strobe (LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL)
//   busy                       source must hold data (all states except DA and LD)
// ---------------------------------------------------------------------------
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    LP  = 3'd3,
    FFS = 3'd4,
    LAF = 3'd5,
    WTE = 3'd6,
    CPE = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       r_rst_ok;

  logic [3:0] w_empty;
  logic [3:0] w_srst;
  logic       w_empty_sel;
  logic       w_srst_sel;
  logic       w_hdr_ok;

  // Bit 3 pads the vectors so a 2-bit index never falls outside them.
  // Address 3 is never latched, so it reads "not empty / no soft reset".
  assign w_empty     = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_srst      = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign w_empty_sel = w_empty[r_addr];
  assign w_srst_sel  = w_srst[r_addr];
  assign w_hdr_ok    = pkt_valid && (data_in != 2'd3);

  // r_rst_ok holds the FSM in DA for the first edge after reset release. A
  // reset removal that lands close to that edge therefore cannot trigger a
  // partial transition.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= DA;
      r_addr   <= 2'd0;
      r_rst_ok <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rst_ok <= 1'b1;
      if ((r_state == DA) && w_hdr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    if ((r_state != DA) && w_srst_sel) begin
      w_next = DA;
    end else begin
      case (r_state)
        // In DA the address is still on data_in, not yet in r_addr.
        DA:  if (w_hdr_ok && r_rst_ok)
               w_next = w_empty[data_in] ? LFD : WTE;
        LFD: w_next = LD;
        LD:  if (fifo_full)       w_next = FFS;
             else if (!pkt_valid) w_next = LP;
        FFS: if (!fifo_full)      w_next = LAF;
        LAF: if (parity_done)           w_next = DA;
             else if (low_packet_valid) w_next = LP;
             else                       w_next = LD;
        LP:  w_next = CPE;
        CPE: w_next = fifo_full ? FFS : DA;
        WTE: if (w_empty_sel)     w_next = LFD;
        default: w_next = DA;
      endcase
    end
  end

  // Moore outputs: pure decode of the state register.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (r_state)
      DA:  begin detect_add = 1'b1; busy = 1'b0; end
      LFD: lfd_state = 1'b1;
      LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b0; end
      LP:  write_enb_reg = 1'b1;
      FFS: full_state = 1'b1;
      LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; end
      CPE: rst_int_reg = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] empty;
  logic [2:0] srst;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]), .fifo_empty_2(empty[2]),
    .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  // Reference model: phase names as strings, transitions written as the
  // packet-level rules, outputs looked up from per-phase membership.
  string m_phase;
  int    m_addr;
  bit    m_armed;   // first post-reset edge has passed

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %b expected %b (phase %s)", tag, obs, exp, m_phase);
    end
  endtask

  function automatic logic [7:0] expected_outs(input string ph);
    logic [7:0] v;
    v[7] = (ph == "DA");
    v[6] = (ph == "LFD");
    v[5] = (ph == "LD");
    v[4] = (ph == "LAF");
    v[3] = (ph == "FFS");
    v[2] = (ph == "CPE");
    v[1] = (ph == "LD") || (ph == "LP") || (ph == "LAF");
    v[0] = !((ph == "DA") || (ph == "LD"));
    return v;
  endfunction

  function automatic logic [7:0] dut_outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  task automatic model_step();
    string nx;
    int    a;
    nx = m_phase;
    if (!resetn) begin
      m_phase = "DA"; m_addr = 0; m_armed = 0;
      return;
    end
    a = int'(data_in);
    if (m_phase != "DA" && srst[m_addr]) nx = "DA";
    else if (m_phase == "DA") begin
      if (m_armed && pkt_valid && a != 3) nx = empty[a] ? "LFD" : "WTE";
    end
    else if (m_phase == "LFD") nx = "LD";
    else if (m_phase == "LD")  nx = fifo_full ? "FFS" : (!pkt_valid ? "LP" : "LD");
    else if (m_phase == "FFS") nx = fifo_full ? "FFS" : "LAF";
    else if (m_phase == "LAF") nx = parity_done ? "DA" : (low_packet_valid ? "LP" : "LD");
    else if (m_phase == "LP")  nx = "CPE";
    else if (m_phase == "CPE") nx = fifo_full ? "FFS" : "DA";
    else if (m_phase == "WTE") nx = empty[m_addr] ? "LFD" : "WTE";
    if (m_phase == "DA" && pkt_valid && a != 3) m_addr = a;
    m_armed = 1;
    m_phase = nx;
  endtask

  // One clock: inputs already set (we are at a negedge), model follows the
  // edge, outputs compared at the next negedge.
  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    @(negedge clock);
    check(tag, dut_outs(), expected_outs(m_phase));
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0; empty = 3'b111; srst = 0;
    parity_done = 0; low_packet_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 0;
    #1;
    m_phase = "DA"; m_addr = 0; m_armed = 0;
    check("reset_async", dut_outs(), 8'b1000_0000);
    @(negedge clock);
    resetn = 1;
  endtask

  int wen_cnt;

  initial begin
    idle_inputs();
    resetn = 0;
    m_phase = "DA"; m_addr = 0; m_armed = 0;
    #12;
    check("reset_state", dut_outs(), 8'b1000_0000);
    @(negedge clock);
    resetn = 1;
    tick("post_reset_idle");
    tick("post_reset_idle2");

    // Normal packet to port 2 with three payload cycles.
    wen_cnt = 0;
    pkt_valid = 1; data_in = 2; empty = 3'b100;
    tick("norm_hdr");                 // LFD
    data_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick("norm_pay");               // LD, LD, LD
      wen_cnt += int'(write_enb_reg);
    end
    pkt_valid = 0;
    tick("norm_lp"); wen_cnt += int'(write_enb_reg);
    tick("norm_cpe"); wen_cnt += int'(write_enb_reg);
    tick("norm_done"); wen_cnt += int'(write_enb_reg);
    check("norm_wen_cycles", 8'(wen_cnt), 8'd4);
    check("norm_end_da", dut_outs(), 8'b1000_0000);

    // Busy destination: wait in WTE until port 1 drains.
    pkt_valid = 1; data_in = 1; empty = 3'b000;
    tick("wte_enter");
    check("wte_busy", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 5; i++) tick("wte_hold");
    empty = 3'b010;
    tick("wte_to_lfd");
    check("wte_lfd", {7'd0, lfd_state}, 8'd1);
    tick("lfd_to_ld");

    // Full stall, leave via LAF to LD.
    fifo_full = 1;
    tick("ffs_enter");
    check("ffs_busy_wen", {6'd0, busy, write_enb_reg}, 8'b10);
    tick("ffs_hold");
    fifo_full = 0;
    tick("laf");
    tick("laf_to_ld");
    // Stall again, leave via LAF to LP (low_packet_valid).
    fifo_full = 1; tick("ffs2");
    fifo_full = 0; tick("laf2");
    low_packet_valid = 1; tick("laf_to_lp");
    low_packet_valid = 0; tick("lp_to_cpe");
    tick("cpe_to_da");

    // Stall, leave via LAF to DA (parity_done).
    pkt_valid = 1; data_in = 0; empty = 3'b001;
    tick("p0_lfd"); tick("p0_ld");
    fifo_full = 1; tick("ffs3");
    fifo_full = 0; tick("laf3");
    parity_done = 1; tick("laf_to_da");
    parity_done = 0;

    // Soft reset of the addressed port aborts; other port is ignored.
    tick("sr_lfd"); tick("sr_ld");
    srst = 3'b010; tick("sr_other_port");
    check("sr_other_stays_ld", {7'd0, ld_state}, 8'd1);
    srst = 3'b001; tick("sr_own_port");
    check("sr_own_da", {7'd0, detect_add}, 8'd1);
    srst = 0;

    // Invalid address: stays in DA; latched address still 0 so a port-0
    // soft reset later must abort the next packet to port 0 only.
    data_in = 3; tick("bad_addr");
    check("bad_addr_busy", {7'd0, busy}, 8'd0);
    tick("bad_addr2");
    pkt_valid = 0; tick("idle");

    // Async reset in the middle of LD.
    pkt_valid = 1; data_in = 2; empty = 3'b111;
    tick("r_lfd"); tick("r_ld");
    do_reset();
    tick("after_release");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      pkt_valid        = ($urandom_range(0, 9) < 7);
      data_in          = 2'($urandom_range(0, 3));
      fifo_full        = ($urandom_range(0, 3) == 0);
      empty            = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 9) < 6)};
      srst             = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 19) == 0)};
      parity_done      = ($urandom_range(0, 4) == 0);
      low_packet_valid = ($urandom_range(0, 2) == 0);
      if ((i % 997) == 500) do_reset();
      else tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
